// File: rtl/bxu_pkg.sv
// Shared encodings for the data-address sequencer: command codes, opcodes,
// instruction bit positions and the sequencer state enum.
package bxu_pkg;

  localparam logic [1:0] DADDR_NOP = 2'h0;
  localparam logic [1:0] DADDR_MOD = 2'h1;
  localparam logic [1:0] DADDR_SET = 2'h2;

  localparam logic [3:0] OP_DMOD = 4'h3;
  localparam logic [3:0] OP_DSET = 4'h4;

  localparam int CODE_PN  = 15;
  localparam int CODE_MEM = 13;
  localparam int CODE_LH  = 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MREQ,
    ST_MWAIT,
    ST_EXEC,
    ST_RETIRE
  } daddr_state_e;

  function automatic logic [3:0] code_op(input logic [15:0] c);
    return c[3:0];
  endfunction

  function automatic logic code_mem(input logic [15:0] c);
    return c[CODE_MEM];
  endfunction

  function automatic logic code_sub(input logic [15:0] c);
    return c[CODE_PN];
  endfunction

  function automatic logic code_high(input logic [15:0] c);
    return c[CODE_LH];
  endfunction

endpackage

// File: rtl/daddr_seq.sv
// Data-address update sequencer: decodes DMOD/DSET codes, fetches the byte for
// memory-sourced DSET, and issues one registered command per instruction.
// Optional macro DADDR_SEQ_TIMEOUT_EN bounds the memory wait to TIMEOUT_CYCLES.
module daddr_seq
  import bxu_pkg::*;
#(
  parameter int DATA_BITWIDTH  = 8,
  parameter int CODE_BITWIDTH  = 16,
  parameter int ADDR_BITWIDTH  = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     inst_valid,
  output logic                     inst_ready,
  input  logic [CODE_BITWIDTH-1:0] inst_code,
  input  logic [ADDR_BITWIDTH-1:0] data_addr,
  output logic                     mem_req,
  output logic [ADDR_BITWIDTH-1:0] mem_addr,
  input  logic                     mem_gnt,
  input  logic                     mem_rvalid,
  input  logic [DATA_BITWIDTH-1:0] mem_rdata,
  output logic [1:0]               flag_op_daddr,
  output logic [CODE_BITWIDTH-1:0] code,
  output logic [DATA_BITWIDTH-1:0] data,
  output logic                     done,
  output logic                     err
);

  daddr_state_e state, state_nxt;

  logic [1:0]               flag_nxt;
  logic [CODE_BITWIDTH-1:0] code_nxt;
  logic [DATA_BITWIDTH-1:0] data_nxt;
  logic                     mem_req_nxt;
  logic [ADDR_BITWIDTH-1:0] mem_addr_nxt;
  logic                     done_nxt;
  logic                     err_nxt;

`ifdef DADDR_SEQ_TIMEOUT_EN
  logic [7:0] wait_cnt, wait_cnt_nxt;
  logic       timeout;
  assign timeout = (wait_cnt == 8'(TIMEOUT_CYCLES - 1));
`endif

  assign inst_ready = (state == ST_IDLE);

  always_comb begin
    state_nxt    = state;
    code_nxt     = code;
    data_nxt     = data;
    mem_req_nxt  = mem_req;
    mem_addr_nxt = mem_addr;
`ifdef DADDR_SEQ_TIMEOUT_EN
    wait_cnt_nxt = wait_cnt + 8'd1;
`endif

    case (state)
      ST_IDLE: begin
        if (inst_valid) begin
          code_nxt = inst_code;
`ifdef DADDR_SEQ_TIMEOUT_EN
          wait_cnt_nxt = '0;
`endif
          if (code_op(inst_code) == OP_DMOD ||
              (code_op(inst_code) == OP_DSET && !code_mem(inst_code))) begin
            state_nxt = ST_EXEC;
          end else if (code_op(inst_code) == OP_DSET) begin
            state_nxt    = ST_MREQ;
            mem_req_nxt  = 1'b1;
            mem_addr_nxt = data_addr;
          end else begin
            state_nxt = ST_RETIRE;
          end
        end
      end
      ST_MREQ: begin
        // A response arriving with the grant is taken as the read data.
        if (mem_gnt) begin
          mem_req_nxt = 1'b0;
          if (mem_rvalid) begin
            data_nxt  = mem_rdata;
            state_nxt = ST_EXEC;
          end else begin
            state_nxt = ST_MWAIT;
          end
        end
`ifdef DADDR_SEQ_TIMEOUT_EN
        else if (timeout) begin
          mem_req_nxt = 1'b0;
          state_nxt   = ST_RETIRE;
        end
`endif
      end
      ST_MWAIT: begin
        if (mem_rvalid) begin
          data_nxt  = mem_rdata;
          state_nxt = ST_EXEC;
        end
`ifdef DADDR_SEQ_TIMEOUT_EN
        else if (timeout) begin
          state_nxt = ST_RETIRE;
        end
`endif
      end
      default: state_nxt = ST_IDLE;
    endcase

    // Pulsed outputs are decoded from the destination state so they register
    // in the same cycle the sequencer occupies EXEC/RETIRE.
    flag_nxt = DADDR_NOP;
    if (state_nxt == ST_EXEC)
      flag_nxt = (code_op(code_nxt) == OP_DMOD) ? DADDR_MOD : DADDR_SET;
    done_nxt = (state_nxt == ST_EXEC) || (state_nxt == ST_RETIRE);
    err_nxt  = (state_nxt == ST_RETIRE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      flag_op_daddr <= DADDR_NOP;
      code          <= '0;
      data          <= '0;
      mem_req       <= 1'b0;
      mem_addr      <= '0;
      done          <= 1'b0;
      err           <= 1'b0;
`ifdef DADDR_SEQ_TIMEOUT_EN
      wait_cnt      <= '0;
`endif
    end else begin
      state         <= state_nxt;
      flag_op_daddr <= flag_nxt;
      code          <= code_nxt;
      data          <= data_nxt;
      mem_req       <= mem_req_nxt;
      mem_addr      <= mem_addr_nxt;
      done          <= done_nxt;
      err           <= err_nxt;
`ifdef DADDR_SEQ_TIMEOUT_EN
      wait_cnt      <= wait_cnt_nxt;
`endif
    end
  end

endmodule

// File: doc/daddr_seq.md
Name: daddr_seq

Overview:
- Sequencer that drives the data-address register's 2-bit update command (NOP/MOD/SET) from a stream of 16-bit instruction codes.
- Decodes the daddr-class opcodes and accepts instructions on a valid/ready handshake.
- For memory-sourced SET, performs a one-byte read at the current data address through a req/gnt + rvalid port, then issues the SET with the returned byte.
- Sits between the instruction fetch/issue stage and the data-address register.

Parameters:
- DATA_BITWIDTH, 8, memory data width
- CODE_BITWIDTH, 16, instruction code width
- ADDR_BITWIDTH, 16, data address width
- OP_DMOD, 4'h3, code[3:0] value for address modify
- OP_DSET, 4'h4, code[3:0] value for address byte set
- DADDR_NOP, 2'h0, command encoding: hold
- DADDR_MOD, 2'h1, command encoding: add/sub code[14:4]
- DADDR_SET, 2'h2, command encoding: byte load
- TIMEOUT_CYCLES, 255, memory wait limit (only with optional feature)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- inst_valid  in  1  instruction code valid
- inst_ready  out  1  sequencer can accept a code
- inst_code  in  CODE_BITWIDTH  instruction code
- data_addr  in  ADDR_BITWIDTH  current value of the data-address register
- mem_req  out  1  memory read request
- mem_addr  out  ADDR_BITWIDTH  read address
- mem_gnt  in  1  request accepted
- mem_rvalid  in  1  read data valid
- mem_rdata  in  DATA_BITWIDTH  read data
- flag_op_daddr  out  2  command to the address register
- code  out  CODE_BITWIDTH  latched code presented with the command
- data  out  DATA_BITWIDTH  latched memory byte presented with the command
- done  out  1  one-cycle retire pulse
- err  out  1  one-cycle error pulse (illegal opcode or timeout)

Behaviour:
- Reset values: state IDLE; flag_op_daddr=DADDR_NOP; code=0; data=0; mem_req=0; mem_addr=0; done=0; err=0. inst_ready=1 in IDLE only.
- All outputs are registered except inst_ready, which is decoded from state.
- Decode of the accepted code: op=code[3:0]; mem=code[13].
- IDLE: an instruction is accepted when inst_valid && inst_ready; latch the code, then:
  - op==OP_DMOD, or op==OP_DSET with mem=0 -> EXEC.
  - op==OP_DSET with mem=1 -> MREQ; assert mem_req=1 with mem_addr=data_addr sampled in the accept cycle.
  - Any other op -> go to RETIRE with err=1; no command is issued.
- MREQ: hold mem_req and mem_addr stable until mem_gnt. On mem_gnt, deassert mem_req the next cycle and go to MWAIT. If mem_rvalid arrives in the same cycle as mem_gnt, treat it as the read data and go straight to EXEC.
- MWAIT: on mem_rvalid, latch data=mem_rdata -> EXEC. mem_rvalid outside MREQ/MWAIT is ignored.
- EXEC: drive flag_op_daddr=DADDR_MOD (DMOD) or DADDR_SET (DSET) for exactly one cycle with code (and data) stable; done=1 in the same cycle; next state IDLE. In every other state flag_op_daddr=DADDR_NOP.
- RETIRE: done=1 and err=1 for one cycle -> IDLE.
- Latency, accept edge to command cycle:
  - Non-memory op: 1 cycle.
  - Memory op: 1 cycle after mem_rvalid.
  - Back-to-back throughput: one instruction per 2 cycles (EXEC/RETIRE has inst_ready=0).
- data holds its last latched value; it changes only on mem_rvalid capture.
- Reset mid-operation returns to IDLE immediately and drops mem_req asynchronously. Any outstanding read response after reset is ignored.

Optional Feature:
- Macro DADDR_SEQ_TIMEOUT_EN.
- Defined: an 8+ bit cycle counter clears on entry to MREQ and counts in MREQ/MWAIT. When it reaches TIMEOUT_CYCLES: drop mem_req, issue no command, go to RETIRE (done=1, err=1).
- Undefined: no counter; the sequencer waits indefinitely.

Decomposition:
- Shared package bxu_pkg holds the DADDR_NOP/MOD/SET encodings, the OP_DMOD/OP_DSET opcodes, the code bit positions (pn=15, mem=13, lh=12) and the state enum.
- No sub-module is needed; the optional timeout counter stays inline.

Test Plan:
- Reset, then code 16'h0033 (DMOD, +3) with valid -> accepted at cycle 0; flag=DADDR_MOD and code=16'h0033 at cycle 1; done=1; inst_ready back to 1 at cycle 2.
- code 16'h1AB4 (DSET imm, high byte) -> flag=DADDR_SET for one cycle at cycle 1; mem_req never asserted.
- code 16'h2004 (DSET mem), data_addr=16'h1234, gnt after 3 cycles, rvalid 2 cycles later with 8'h5A -> mem_addr=16'h1234 while req; data=8'h5A and flag=DADDR_SET the cycle after rvalid.
- code 16'h0007 (illegal op) -> no command; done=1 and err=1 in cycle 1.
- rst_n low while in MWAIT, then a late rvalid -> mem_req=0 immediately; outputs at reset values; no command issued.
- With DADDR_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=4, gnt never asserted -> mem_req drops after 4 cycles; err=1 and done=1; flag stays DADDR_NOP.
